// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle: digit values in, scanned anode/segment drive out.
// No valid/ready: inputs are level signals sampled only at each frame boundary.
interface seg7_scan_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();
    localparam int IW = idx_width(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_n;
    logic                    frame_start;
    scan_state_t             dbg_state;
    logic [IW-1:0]           dbg_idx;

    modport master (
        output digits, dp, blank_lz,
        input  an, seg, dp_n, frame_start, dbg_state, dbg_idx
    );

    modport slave (
        input  digits, dp, blank_lz,
        output an, seg, dp_n, frame_start, dbg_state, dbg_idx
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment driver with per-slot dead time and
// once-per-frame shadow latching of the displayed value.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_CNT = 100000,
    parameter int BLANK_CNT   = 1000
) (
    input  logic        clk,
    input  logic        rst_ext,
    seg7_scan_if.slave  bus
);
    localparam int CNT_MAX = max_int(BLANK_CNT, REFRESH_CNT);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = idx_width(NUM_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CNT - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CNT - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || REFRESH_CNT < 1 || BLANK_CNT < 1) begin : g_param_check
        $error("seg7_scan: NUM_DIGITS, REFRESH_CNT and BLANK_CNT must all be >= 1");
    end

    scan_state_t             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic                    blz_sh_q, blz_sh_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_start_q, frame_start_d;
    logic                    load;

    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic [6:0]              dec_seg;

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            digits_sh_q   <= '0;
            dp_sh_q       <= '0;
            blz_sh_q      <= 1'b1;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            digits_sh_q   <= digits_sh_d;
            dp_sh_q       <= dp_sh_d;
            blz_sh_q      <= blz_sh_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        digits_sh_d = digits_sh_q;
        dp_sh_d     = dp_sh_q;
        blz_sh_d    = blz_sh_q;
        load        = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == REFRESH_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        // Frame wrap: the only point where new input values are taken.
                        idx_d       = '0;
                        load        = 1'b1;
                        digits_sh_d = bus.digits;
                        dp_sh_d     = bus.dp;
                        blz_sh_d    = bus.blank_lz;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // A digit is a leading zero when it and everything above it is zero with no dp.
    always_comb begin
        logic all_zero;
        blank_vec = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero & (digits_sh_d[4*i +: 4] == 4'h0) & ~dp_sh_d[i];
            blank_vec[i] = blz_sh_d & all_zero;
        end
    end

    assign nib_sel = digits_sh_d[4*idx_d +: 4];
    assign dp_sel  = dp_sh_d[idx_d];

    seg7_decode u_decode (
        .nib (nib_sel),
        .seg (dec_seg)
    );

    // Outputs are computed from next-cycle values so they register alongside state.
    always_comb begin
        an_d          = '1;
        seg_d         = SEG_OFF;
        dp_n_d        = 1'b1;
        frame_start_d = load;
        if (state_d == SHOW && !blank_vec[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = dec_seg;
            dp_n_d      = ~dp_sel;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = frame_start_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_idx     = idx_q;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed seven-segment display driver for the calculator datapath. It time-multiplexes `NUM_DIGITS` hex digits onto a shared active-low segment bus. A dead-time blanking interval separates digit slots to prevent ghosting. It is the output-side counterpart of the pushbutton input conditioning. Inputs are shadow-latched once per frame so a value change never tears mid-frame.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (≥1); digit 0 is rightmost/least significant.
- `REFRESH_CNT`, 100000: cycles a digit is lit per slot (≥1).
- `BLANK_CNT`, 1000: dead-time cycles per slot with all anodes off (≥1).
- `clk` in 1: system clock, single clock domain.
- `rst_ext` in 1: reset, synchronous, active-high.
- `digits` in 4*NUM_DIGITS: hex nibbles; digit i = `digits[4i+3:4i]`.
- `dp` in NUM_DIGITS: decimal point request per digit, 1 = lit.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `an` out NUM_DIGITS: anode enables, active-low.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n` out 1: decimal point segment, active-low.
- `frame_start` out 1: one-cycle pulse marking the shadow-register load.

## Operation
- FSM states: BLANK and SHOW. Per-state counter `cnt` counts 0..BLANK_CNT-1 in BLANK and 0..REFRESH_CNT-1 in SHOW. Digit index `idx` ranges 0..NUM_DIGITS-1.
- BLANK → SHOW on `cnt==BLANK_CNT-1`. `cnt` clears and `idx` is held.
- SHOW → BLANK on `cnt==REFRESH_CNT-1`. `cnt` clears.
  - `idx` increments on this transition.
  - When `idx==NUM_DIGITS-1`, `idx` wraps to 0, `digits`/`dp`/`blank_lz` are latched into shadow registers, and `frame_start` is asserted.
- Display logic uses only the shadow registers. Input changes are invisible until the next wrap.
- Leading-zero suppression applies when shadow `blank_lz`=1. Digit i (i>0) is blank when its nibble and every higher nibble are 0 and no `dp` bit at index ≥ i is set. Digit 0 is never blank.
- In BLANK: `an` all ones, `seg`=7'h7F, `dp_n`=1.
- In SHOW, non-blank digit: `an[idx]`=0 with all other bits 1, `seg`=decode(nibble), `dp_n`=~dp[idx].
- In SHOW, blank digit: `an` all ones, `seg`=7'h7F, `dp_n`=1.
- Hex decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

## Timing
- Reset (`rst_ext`=1 at a clock edge) sets:
  - outputs: `an` all ones, `seg`=7'h7F, `dp_n`=1, `frame_start`=0;
  - state: BLANK, `cnt`=0, `idx`=0;
  - shadow: `digits`=0, `dp`=0, `blank_lz`=1.
- Reset wins over every other event. Reset mid-slot aborts the slot immediately.
- `an`, `seg`, `dp_n` and `frame_start` are registers updated on the same edge as state/`idx`. There is no extra pipeline latency.
- Slot length is BLANK_CNT+REFRESH_CNT cycles. Frame length is NUM_DIGITS×slot.
- After reset release, the first frame displays the reset shadow (only digit 0 lit, showing "0"). The first `frame_start` occurs one frame after reset release.
- `frame_start` is high for exactly one cycle: the first BLANK cycle of digit 0.
- An input change on the same edge as a shadow load is captured. Input values from earlier cycles are ignored.

## Structure
- Package `seg7_pkg`:
  - 16-entry `localparam logic [6:0]` hex segment table;
  - constant `SEG_OFF`=7'h7F;
  - `typedef enum logic {BLANK, SHOW} scan_state_t`.
- Sub-module `seg7_decode`: combinational nibble → active-low segments using the package table. It is instantiated once on the shadow nibble at `idx`.
- Counter width is `$clog2(max(BLANK_CNT,REFRESH_CNT))`, minimum 1 bit.
- Elaboration-time assertion that NUM_DIGITS, REFRESH_CNT and BLANK_CNT are ≥1.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_CNT=8, BLANK_CNT=2 (slot 10 cycles, frame 40).
- Reset then release, inputs held at 0:
  - cycles 0-1: `an`=4'hF;
  - cycles 2-9: `an`=4'hE, `seg`=40;
  - digits 1-3 slots: `an`=4'hF;
  - `frame_start` pulses at cycle 40 only.
- `digits`=16'h0012, `blank_lz`=1, after first load:
  - digit 1 slot: `an`=4'hD, `seg`=79;
  - digit 0 slot: `an`=4'hE, `seg`=24;
  - digit 2/3 slots: `an`=4'hF.
- `digits`=16'h8F0A, `blank_lz`=0, `dp`=4'b0100:
  - digit 0 shows 08; digit 1 shows 40;
  - digit 2 shows 0E with `dp_n`=0; digit 3 shows 00.
- Change `digits` mid-frame: the displayed value is unchanged until the cycle after `frame_start`, then the new value appears.
- Assert `rst_ext` during the SHOW of digit 2 for one cycle: the next cycle has `an`=4'hF and `idx`=0. The sequence restarts exactly as in the reset-release scenario.
- `digits`=16'h0000, `dp`=4'b0100, `blank_lz`=1: digits 2, 1 and 0 are lit (digit 2 with `dp_n`=0); digit 3 is blank.
